// File: rtl/i2s_audio_out.sv
// I2S output stage: accepts 12-bit offset-binary mono samples, converts them to
// 16-bit two's complement and serialises each word on both channels of a
// Philips I2S stream. Emits a per-frame strobe and an underrun pulse.
module i2s_audio_out #(
   parameter int unsigned CLK_DIV = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] sample_in,
   input  logic        sample_valid,
   output logic        sample_ready,
   output logic        i2s_bclk,
   output logic        i2s_lrclk,
   output logic        i2s_sdata,
   output logic        frame_pulse,
   output logic        underrun
);

   localparam int unsigned SAMPLE_W = 12;
   localparam int unsigned WORD_W   = 16;
   localparam int unsigned FRAME_W  = 2 * WORD_W;
   localparam int unsigned DIV_W    = 8;
   localparam int unsigned BIT_W    = 5;
   localparam int unsigned PAD_W    = WORD_W - SAMPLE_W;

   localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] SLOT_LOAD   = BIT_W'(1);
   localparam logic [BIT_W-1:0] SLOT_RIGHT  = BIT_W'(WORD_W);
   localparam logic [BIT_W-1:0] SLOT_LEFT   = BIT_W'(0);

   // Divider and bit-slot state
   logic [DIV_W-1:0]   div_cnt;
   logic [BIT_W-1:0]   bit_cnt;

   // Datapath state
   logic [FRAME_W-1:0] shift_reg;
   logic [WORD_W-1:0]  last_word;
   logic [WORD_W-1:0]  hold_word;
   logic               hold_full;

   // Combinational helpers
   logic               div_wrap;
   logic               bclk_fall;
   logic [BIT_W-1:0]   bit_next;
   logic               load;
   logic               accept;
   logic [WORD_W-1:0]  conv_word;
   logic [WORD_W-1:0]  load_word;
   logic               hold_full_next;

   // Offset-binary to two's complement: flip the sign bit and left-justify.
   always_comb begin
      conv_word = {~sample_in[SAMPLE_W-1], sample_in[SAMPLE_W-2:0], {PAD_W{1'b0}}};
   end

   // Event decode: divider wrap, BCLK falling edge, and frame load slot.
   always_comb begin
      div_wrap  = (div_cnt == DIV_LAST);
      bclk_fall = div_wrap && i2s_bclk;
      bit_next  = bit_cnt + BIT_W'(1);
      load      = bclk_fall && (bit_next == SLOT_LOAD);
      accept    = sample_valid && sample_ready;
      load_word = hold_full ? hold_word : last_word;
   end

   // Holding-register occupancy after this edge; a load frees it before an accept refills it.
   always_comb begin
      hold_full_next = hold_full;
      if (load) begin
         hold_full_next = 1'b0;
      end
      if (accept) begin
         hold_full_next = 1'b1;
      end
   end

   // Clock divider producing the bit clock.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt  <= '0;
         i2s_bclk <= 1'b0;
      end else if (div_wrap) begin
         div_cnt  <= '0;
         i2s_bclk <= ~i2s_bclk;
      end else begin
         div_cnt  <= div_cnt + DIV_W'(1);
      end
   end

   // Bit-slot counter and word select, advanced on each BCLK falling edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt   <= '0;
         i2s_lrclk <= 1'b0;
      end else if (bclk_fall) begin
         bit_cnt <= bit_next;
         if (bit_next == SLOT_RIGHT) begin
            i2s_lrclk <= 1'b1;
         end else if (bit_next == SLOT_LEFT) begin
            i2s_lrclk <= 1'b0;
         end
      end
   end

   // Serialiser: load a fresh frame at slot 1, otherwise shift out MSB first.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg <= '0;
         i2s_sdata <= 1'b0;
         last_word <= '0;
      end else if (load) begin
         shift_reg <= {load_word, load_word};
         i2s_sdata <= load_word[WORD_W-1];
         last_word <= load_word;
      end else if (bclk_fall) begin
         shift_reg <= {shift_reg[FRAME_W-2:0], 1'b0};
         i2s_sdata <= shift_reg[FRAME_W-2];
      end
   end

   // Single-cycle frame strobe and underrun flag, both tied to the load event.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_pulse <= 1'b0;
         underrun    <= 1'b0;
      end else begin
         frame_pulse <= load;
         underrun    <= load && !hold_full;
      end
   end

   // One-deep holding register with valid/ready handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_word    <= '0;
         hold_full    <= 1'b0;
         sample_ready <= 1'b0;
      end else begin
         if (accept) begin
            hold_word <= conv_word;
         end
         hold_full    <= hold_full_next;
         sample_ready <= !hold_full_next;
      end
   end

endmodule
